// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction-fetch sequencer with a 2-entry decode queue
module ifetch_ctrl #(
   parameter int MEM_DEPTH = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] mem_pc,
   input  logic [31:0] mem_inst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        busy,
   output logic        halted
);
   localparam int            PW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PC = PW'(MEM_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]    count_q, count_d;
   logic [31:0]   inst_q [2];
   logic [31:0]   inst_d [2];
   logic [PW-1:0] epc_q [2];
   logic [PW-1:0] epc_d [2];
   logic          pop;
   logic          slot;

   // State, program counter and queue storage registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= '0;
         count_q    <= '0;
         inst_q[0]  <= '0;
         inst_q[1]  <= '0;
         epc_q[0]   <= '0;
         epc_q[1]   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         inst_q[0]  <= inst_d[0];
         inst_q[1]  <= inst_d[1];
         epc_q[0]   <= epc_d[0];
         epc_q[1]   <= epc_d[1];
      end
   end

   // Sequencing: start, redirect flush, pop-then-push queue update, end of program
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      inst_d     = inst_q;
      epc_d      = epc_q;
      pop        = (count_q != 2'd0) && out_ready;
      // Queue position the pushed word lands in once any pop has shifted the head out
      slot       = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               fetch_pc_d = '0;
               count_d    = '0;
               inst_d[0]  = '0;
               inst_d[1]  = '0;
               epc_d[0]   = '0;
               epc_d[1]   = '0;
            end
         end
         RUN, DRAIN: begin
            if (redirect) begin
               // Any head handshake this cycle simply completes; everything left is dropped
               state_d    = RUN;
               fetch_pc_d = PW'(redirect_pc % 32'(MEM_DEPTH));
               count_d    = '0;
               inst_d[0]  = '0;
               inst_d[1]  = '0;
               epc_d[0]   = '0;
               epc_d[1]   = '0;
            end else begin
               if (pop) begin
                  inst_d[0] = inst_q[1];
                  epc_d[0]  = epc_q[1];
                  inst_d[1] = '0;
                  epc_d[1]  = '0;
                  count_d   = count_q - 2'd1;
               end
               if ((state_q == RUN) && ((count_q != 2'd2) || pop)) begin
                  inst_d[slot] = mem_inst;
                  epc_d[slot]  = fetch_pc_q;
                  count_d      = count_d + 2'd1;
                  if (fetch_pc_q == LAST_PC) begin
                     state_d = DRAIN;
                  end else begin
                     fetch_pc_d = fetch_pc_q + PW'(1);
                  end
               end
               if ((state_q == DRAIN) && (count_d == 2'd0)) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_pc    = 32'(fetch_pc_q);
   assign out_valid = (count_q != 2'd0);
   assign out_inst  = inst_q[0];
   assign out_pc    = 32'(epc_q[0]);
   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign halted    = (state_q == DONE);
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl with a queue-based reference model
module tb_ifetch_ctrl;
   localparam int DEPTH = 128;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

   logic        clk = 1'b0;
   logic        rst, start, out_ready, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] mem_pc, mem_inst, out_inst, out_pc;
   logic        out_valid, busy, halted;

   logic [31:0] mem [DEPTH];

   typedef struct {
      int          pc;
      logic [31:0] inst;
   } ent_t;

   ent_t mq[$];
   int   m_st  = M_IDLE;
   int   m_pc  = 0;
   bit   m_clr = 1'b1;
   bit   armed = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   n;

   ifetch_ctrl #(.MEM_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mem_pc     (mem_pc),
      .mem_inst   (mem_inst),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_inst   (out_inst),
      .out_pc     (out_pc),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .busy       (busy),
      .halted     (halted)
   );

   assign mem_inst = (mem_pc < 32'(DEPTH)) ? mem[mem_pc[6:0]] : 32'hDEAD_BEEF;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Reference model: a FIFO of fetched words advanced once per clock from the sampled inputs
   task automatic model_step();
      if (rst) begin
         m_st = M_IDLE; m_pc = 0; mq.delete(); m_clr = 1'b1; armed = 1'b1;
      end else if (m_st == M_IDLE || m_st == M_DONE) begin
         if (start) begin
            m_st = M_RUN; m_pc = 0; mq.delete(); m_clr = 1'b1;
         end
      end else begin
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (redirect) begin
            mq.delete();
            m_pc  = int'(redirect_pc % 32'(DEPTH));
            m_st  = M_RUN;
            m_clr = 1'b1;
         end else begin
            if (m_st == M_RUN && mq.size() < 2) begin
               mq.push_back('{pc: m_pc, inst: mem[m_pc]});
               m_clr = 1'b0;
               if (m_pc == DEPTH - 1) m_st = M_DRAIN;
               else m_pc++;
            end
            if (m_st == M_DRAIN && mq.size() == 0) m_st = M_DONE;
         end
      end
   endtask

   task automatic compare();
      chk("mem_pc", mem_pc, 32'(m_pc));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("out_pc", out_pc, 32'(mq[0].pc));
         chk("out_inst", out_inst, mq[0].inst);
      end else if (m_clr) begin
         chk("out_pc_clr", out_pc, 32'd0);
         chk("out_inst_clr", out_inst, 32'd0);
      end
      chk("busy", 32'(busy), 32'(m_st == M_RUN || m_st == M_DRAIN));
      chk("halted", 32'(halted), 32'(m_st == M_DONE));
   endtask

   // Model advance on each edge, DUT compared just after it settles
   always @(posedge clk) begin
      model_step();
      if (armed) begin
         #1;
         compare();
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      for (int k = 0; k < DEPTH; k++) mem[k] = 32'(k + 100);
      tick(3);
      rst = 1'b0;
      chk("rst_mem_pc", mem_pc, 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_inst", out_inst, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);

      // Full program with decode always ready
      out_ready = 1'b1; start = 1'b1; tick(1); start = 1'b0;
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_valid_lat", 32'(out_valid), 32'd0);
      tick(1);
      chk("t1_pc0", out_pc, 32'd0);
      chk("t1_inst0", out_inst, 32'd100);
      tick(1);
      chk("t1_pc1", out_pc, 32'd1);
      chk("t1_inst1", out_inst, 32'd101);
      n = 2;
      while (!halted && n < 400) begin tick(1); n++; end
      chk("t1_done_cycles", 32'(n), 32'd129);
      chk("t1_halted", 32'(halted), 32'd1);
      chk("t1_busy_end", 32'(busy), 32'd0);

      // Backpressure
      rst = 1'b1; tick(1); rst = 1'b0;
      out_ready = 1'b0; start = 1'b1; tick(1); start = 1'b0;
      tick(6);
      chk("t2_mem_pc_held", mem_pc, 32'd2);
      chk("t2_head0", out_pc, 32'd0);
      out_ready = 1'b1; tick(1);
      chk("t2_head1", out_pc, 32'd1);
      tick(1);
      chk("t2_head2", out_pc, 32'd2);
      tick(1);
      chk("t2_head3", out_pc, 32'd3);

      // Redirect to 40 with pcs 5,6 queued
      n = 0;
      while (!(mq.size() > 0 && mq[0].pc == 5) && n < 100) begin tick(1); n++; end
      chk("t3_reach5", 32'(n < 100), 32'd1);
      out_ready = 1'b0; tick(1);
      chk("t3_head5", out_pc, 32'd5);
      out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'd40; tick(1); redirect = 1'b0;
      chk("t3_flush_valid", 32'(out_valid), 32'd0);
      chk("t3_mem_pc40", mem_pc, 32'd40);
      tick(1);
      chk("t3_valid40", 32'(out_valid), 32'd1);
      chk("t3_pc40", out_pc, 32'd40);
      chk("t3_inst40", out_inst, 32'd140);

      // Redirect target wraps modulo depth
      redirect = 1'b1; redirect_pc = 32'd130; tick(1); redirect = 1'b0;
      chk("t4_mem_pc2", mem_pc, 32'd2);
      tick(1);
      chk("t4_pc2", out_pc, 32'd2);
      chk("t4_inst2", out_inst, 32'd102);

      // Redirect during drain
      n = 0;
      while (m_st != M_DRAIN && n < 300) begin tick(1); n++; end
      chk("t5_drain_busy", 32'(busy), 32'd1);
      redirect = 1'b1; redirect_pc = 32'd120; tick(1); redirect = 1'b0;
      chk("t5_mem_pc120", mem_pc, 32'd120);
      n = 0;
      while (!halted && n < 50) begin tick(1); n++; end
      chk("t5_done_cycles", 32'(n), 32'd9);

      // Ignored redirect in idle, ignored start in run
      rst = 1'b1; tick(1); rst = 1'b0;
      redirect = 1'b1; redirect_pc = 32'd50; tick(2); redirect = 1'b0;
      chk("t6_idle_mem_pc", mem_pc, 32'd0);
      chk("t6_idle_busy", 32'(busy), 32'd0);
      out_ready = 1'b1; start = 1'b1; tick(1); start = 1'b0;
      tick(4);
      start = 1'b1; tick(1); start = 1'b0;
      chk("t6_run_mem_pc", mem_pc, 32'd5);
      chk("t6_run_head", out_pc, 32'd4);

      // Reset mid-run with a full queue
      out_ready = 1'b0; tick(2);
      chk("t7_full_valid", 32'(out_valid), 32'd1);
      rst = 1'b1; start = 1'b1; redirect = 1'b1; out_ready = 1'b1; tick(1);
      rst = 1'b0; start = 1'b0; redirect = 1'b0; out_ready = 1'b0;
      chk("t7_mem_pc", mem_pc, 32'd0);
      chk("t7_valid", 32'(out_valid), 32'd0);
      chk("t7_inst", out_inst, 32'd0);
      chk("t7_pc", out_pc, 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_halted", 32'(halted), 32'd0);
      out_ready = 1'b1; start = 1'b1; tick(1); start = 1'b0;
      tick(1);
      chk("t7_restart_pc", out_pc, 32'd0);
      chk("t7_restart_inst", out_inst, 32'd100);

      // Randomized traffic over random memory contents
      rst = 1'b1;
      for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
      tick(1); rst = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         out_ready   = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 40) == 0);
         redirect_pc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300))
                                                   : 32'($urandom_range(100, 127));
         start       = ($urandom_range(0, 30) == 0);
         rst         = ($urandom_range(0, 500) == 0);
         tick(1);
      end
      rst = 1'b0; start = 1'b0; redirect = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
